division: RTL and testbench
===========================

Name: division

Overview:
- Sequential restoring divider for the Basys2 calculator; inverse operator of the existing shift-and-add multiplier.
- Divides an 8-bit unsigned dividend by a 4-bit unsigned divisor and produces an 8-bit quotient and 4-bit remainder.
- Computes one quotient bit per clock, controlled by a start/busy/done handshake.
- Sits beside the multiplier in the calculator datapath; the operation-select/display logic drives start and consumes the result.

Parameters:
- N_W, 8, dividend and quotient width.
- D_W, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  N_W  unsigned dividend; captured on the accepted start edge.
- divisor  input  D_W  unsigned divisor; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: quotient, remainder and div_by_zero are valid.
- quotient  output  N_W  result quotient; held until the next accepted start.
- remainder  output  D_W  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, quotient, remainder, div_by_zero, iteration counter and working registers all 0.
- States:
  - IDLE -> RUN on start=1 with divisor!=0.
  - IDLE -> DONE on start=1 with divisor==0.
  - RUN -> DONE when the counter reaches N_W-1 (the last step is done on that edge).
  - DONE -> IDLE unconditionally after one cycle.
- Accept edge k (IDLE, start=1):
  - Latch dividend into the shift register A (N_W bits).
  - Latch divisor into register M.
  - Clear partial remainder R (D_W+1 bits) and counter.
  - Clear div_by_zero.
- RUN step (edges k+1 .. k+N_W), one per edge:
  - {R,A} shifted left 1; the MSB of A enters R[0].
  - If R_shifted >= {1'b0,M}: R = R_shifted - M and A[0] = 1; else R = R_shifted and A[0] = 0.
  - Counter increments.
- On edge k+N_W: quotient <= A, remainder <= R[D_W-1:0], state <= DONE.
- done=1 for exactly the cycle after edge k+N_W (result ready 8 clocks after acceptance); busy=1 from after edge k until after edge k+N_W.
- Divide by zero (divisor==0 at accept edge k):
  - No RUN phase.
  - On edge k: quotient <= all ones (8'hFF), remainder <= 0, div_by_zero <= 1, state <= DONE.
  - done high for the cycle after edge k.
- Outputs quotient, remainder and div_by_zero are stable outside the update edges; they do not change in IDLE.
- Ignored inputs:
  - start during RUN or DONE is ignored; it is not queued.
  - dividend and divisor changes after the accept edge have no effect.
- Width rule: R is D_W+1 bits so the compare never overflows. Remainder < divisor always holds for divisor != 0.
- Boundaries:
  - dividend=0 gives quotient 0, remainder 0 in full latency.
  - divisor=1 gives quotient=dividend, remainder 0.
  - dividend < divisor gives quotient 0, remainder=dividend.
- Reset mid-RUN aborts immediately. No done pulse; outputs read 0.

Decomposition:
- Package calc_pkg:
  - width constants N_W=8 and D_W=4.
  - state enum {IDLE, RUN, DONE} with 2-bit encoding.
  - DIV0_QUOTIENT = all-ones constant.
- One natural sub-module: div_step. Combinational single restoring iteration: inputs R, A MSB, M; outputs next R and quotient bit. The top keeps FSM, counter and registers.

Test Plan:
- Reset, then dividend=200, divisor=7, start 1 cycle -> busy 8 cycles; done pulses once, 8 clocks after accept; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=255, divisor=15 -> quotient=17, remainder=0. Then dividend=9, divisor=10 -> quotient=0, remainder=9.
- dividend=100, divisor=0 -> done the cycle after accept, no busy; quotient=8'hFF, remainder=0, div_by_zero=1. The next valid division clears div_by_zero.
- Start 13/3 and, during RUN, pulse start again with 50/5 and change the inputs -> the second start is ignored; result is quotient=4, remainder=1 with exactly one done pulse.
- Start 200/7, assert rst asynchronously mid-cycle at step 4 -> all outputs 0 immediately, no done. After release, 200/7 again -> 28 r 4.
- Random sweep of all 256x16 operand pairs -> quotient*divisor+remainder==dividend and remainder<divisor for divisor!=0; divisor 0 -> 8'hFF, 0, div_by_zero=1.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, state encoding and constants for the calculator divider
package calc_pkg;
  localparam int N_W   = 8;
  localparam int D_W   = 4;
  localparam int CNT_W = $clog2(N_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_W-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/division_if.sv
// rtl/division_if.sv - start/busy/done operand and result bundle for the divider
interface division_if;
  import calc_pkg::*;

  logic           start;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           busy;
  logic           done;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/division_div_step.sv
// rtl/division_div_step.sv - one combinational restoring-division iteration
module div_step
  import calc_pkg::*;
(
  input  logic [D_W:0]   r,
  input  logic           a_msb,
  input  logic [D_W-1:0] m,
  output logic [D_W:0]   r_next,
  output logic           q_bit
);
  logic [D_W:0] r_sh;

  // R stays below M between steps, so its top bit is always zero before the shift.
  assign r_sh   = {r[D_W-1:0], a_msb};
  assign q_bit  = (r_sh >= {1'b0, m});
  assign r_next = q_bit ? (r_sh - {1'b0, m}) : r_sh;
endmodule

// File: rtl/division.sv
// rtl/division.sv - sequential restoring divider, one quotient bit per clock
module division
  import calc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  division_if.slave bus
);
  state_t           state, state_nxt;
  logic [N_W-1:0]   a_q, a_nxt;
  logic [D_W-1:0]   m_q;
  logic [D_W:0]     r_q, r_nxt;
  logic             q_bit;
  logic [CNT_W-1:0] cnt_q;
  logic             last_step;
  logic [N_W-1:0]   quotient_q;
  logic [D_W-1:0]   remainder_q;
  logic             div_by_zero_q;
  logic             busy_c, done_c;

  div_step u_step (
    .r      (r_q),
    .a_msb  (a_q[N_W-1]),
    .m      (m_q),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  assign a_nxt     = {a_q[N_W-2:0], q_bit};
  assign last_step = (cnt_q == CNT_W'(N_W-1));

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      m_q           <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          a_q           <= bus.dividend;
          m_q           <= bus.divisor;
          r_q           <= '0;
          cnt_q         <= '0;
          div_by_zero_q <= (bus.divisor == '0);
          // Divide by zero skips RUN, so its result is published on the accept edge.
          if (bus.divisor == '0) begin
            quotient_q  <= DIV0_QUOTIENT;
            remainder_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          r_q   <= r_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            quotient_q  <= a_nxt;
            remainder_q <= r_nxt[D_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_division.sv
// tb/tb_division.sv - scoreboard bench for the restoring divider
module tb_division;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int q;
    int r;
    int z;
    int due;
  } exp_t;

  exp_t sb[$];

  division_if bus ();

  division dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    int'(bus.quotient),    e.q);
        chk("remainder",   int'(bus.remainder),   e.r);
        chk("div_by_zero", int'(bus.div_by_zero), e.z);
        chk("done_cycle",  cyc,                   e.due);
      end
    end
  end

  task automatic run_div(input int dvd, input int dvs, input int eq, input int er, input int ez);
    exp_t e;
    int   nbusy = 0;
    int   n = 0;
    bus.dividend = 8'(dvd);
    bus.divisor  = 4'(dvs);
    bus.start    = 1'b1;
    e.q = eq; e.r = er; e.z = ez;
    e.due = cyc + ((dvs == 0) ? 1 : 9);
    sb.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    while (!bus.done && n < 20) begin
      if (bus.busy) nbusy++;
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("done_timeout", n, 0);
    chk("busy_cycles", nbusy, (dvs == 0) ? 0 : 8);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #3;
    chk("rst_quotient",  int'(bus.quotient),    0);
    chk("rst_remainder", int'(bus.remainder),   0);
    chk("rst_dbz",       int'(bus.div_by_zero), 0);
    chk("rst_busy",      int'(bus.busy),        0);
    chk("rst_done",      int'(bus.done),        0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_div(200, 7, 28, 4, 0);
    run_div(255, 1, 255, 0, 0);
    run_div(255, 15, 17, 0, 0);
    run_div(9, 10, 0, 9, 0);
    run_div(0, 5, 0, 0, 0);
    run_div(100, 0, 255, 0, 1);
    run_div(77, 6, 12, 5, 0);

    // A second start during RUN must be ignored.
    begin
      exp_t e;
      bus.dividend = 8'd13;
      bus.divisor  = 4'd3;
      bus.start    = 1'b1;
      e.q = 4; e.r = 1; e.z = 0; e.due = cyc + 9;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.dividend = 8'd50;
      bus.divisor  = 4'd5;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("ignored_start_drained", sb.size(), 0);
    end

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_quotient",  int'(bus.quotient),    0);
    chk("abort_remainder", int'(bus.remainder),   0);
    chk("abort_dbz",       int'(bus.div_by_zero), 0);
    chk("abort_busy",      int'(bus.busy),        0);
    chk("abort_done",      int'(bus.done),        0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_result", sb.size(), 0);
    run_div(200, 7, 28, 4, 0);

    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 16; d++) begin
        if (d == 0) run_div(a, d, 255, 0, 1);
        else        run_div(a, d, a / d, a % d, 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
